// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg
// Shared types and widths for the writeback arbiter slice.
//   TAG_W     : width of a ROB destination tag (tag 0 means "no destination")
//   REG_W     : width of an architectural register name
//   WB_FLAG_W : storage width of the per-result flags inside a queued entry;
//               the arbiter's FLAG_W parameter must not exceed it
//   WBEntry   : one completed result as held in a requester queue
package wb_arbiter_pkg;

  localparam int TAG_W     = 6;
  localparam int REG_W     = 5;
  localparam int WB_FLAG_W = 2;

  typedef struct packed {
    logic [31:0]          result;
    logic [TAG_W-1:0]     tag;
    logic [REG_W-1:0]     name;
    logic [WB_FLAG_W-1:0] flags;
  } WBEntry;

endpackage

// File: rtl/wb_queue.sv
// wb_queue
// Shallow per-requester FIFO of WBEntry records in front of the writeback
// arbiter.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (empties the queue)
//   push       : write push_data at the tail (ignored while full)
//   push_data  : entry to enqueue
//   pop        : drop the head entry (ignored while empty)
//   head       : entry at the head of the queue
//   count      : number of stored entries, 0..DEPTH
//   full/empty : count == DEPTH / count == 0, from registered state only
module wb_queue
  import wb_arbiter_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  WBEntry           push_data,
  input  logic             pop,
  output WBEntry           head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  WBEntry           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
  // pointers wrap naturally. A push and a pop in the same cycle leave the
  // count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage. Reset only clears the pointers, so stale data left in
  // here can never be observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // A producer must never push into a full queue; such an entry is lost.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter
// Shares the single ROB writeback port among NUM_REQ functional units.
// Every unit pushes finished results into its own wb_queue; a round-robin
// scheduler forwards at most one queued result per cycle to registered
// outputs, and holds off while the ROB signals a stall.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   IN_valid/IN_*  : per-requester result (tag 0 = nothing to write back)
//   OUT_full       : per-requester queue full, do not push this cycle
//   IN_stall       : ROB cannot accept a write this cycle
//   OUT_valid      : one-cycle write strobe towards the ROB
//   OUT_result/tag/name/flags : granted entry, held while OUT_valid is low
//   OUT_grant      : one-hot requester that supplied the current outputs
// Build option:
//   WB_ARB_BYPASS_EN : a push into an empty queue may be granted in the same
//                      cycle and go straight to the output registers
//                      (one cycle latency instead of two).
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = 2,
  parameter int FLAG_W  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              IN_valid,
  input  logic [NUM_REQ-1:0][31:0]        IN_result,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]   IN_tag,
  input  logic [NUM_REQ-1:0][REG_W-1:0]   IN_name,
  input  logic [NUM_REQ-1:0][FLAG_W-1:0]  IN_flags,
  output logic [NUM_REQ-1:0]              OUT_full,
  input  logic                            IN_stall,
  output logic                            OUT_valid,
  output logic [31:0]                     OUT_result,
  output logic [TAG_W-1:0]                OUT_tag,
  output logic [REG_W-1:0]                OUT_name,
  output logic [FLAG_W-1:0]               OUT_flags,
  output logic [NUM_REQ-1:0]              OUT_grant
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  WBEntry [NUM_REQ-1:0]            in_entry;
  WBEntry [NUM_REQ-1:0]            q_head;
  logic   [NUM_REQ-1:0][CNT_W-1:0] q_count;
  logic   [NUM_REQ-1:0]            req;
  logic   [NUM_REQ-1:0]            q_push;
  logic   [NUM_REQ-1:0]            q_pop;
  logic   [NUM_REQ-1:0]            q_empty;
  logic   [NUM_REQ-1:0]            q_full;
  logic   [NUM_REQ-1:0]            cand;
  logic   [IDX_W-1:0]              rr_ptr;
  logic   [IDX_W-1:0]              grant_idx;
  logic                            grant_any;
  WBEntry                          grant_entry;
  WBEntry                          out_entry;
  logic   [NUM_REQ-1:0]            out_grant;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign in_entry[i] = '{result: IN_result[i],
                           tag:    IN_tag[i],
                           name:   IN_name[i],
                           flags:  WB_FLAG_W'(IN_flags[i])};

    // Results without a destination tag never enter the arbiter.
    assign req[i]   = IN_valid[i] && (IN_tag[i] != '0);
    assign q_pop[i] = grant_any && (grant_idx == IDX_W'(i)) && !q_empty[i];

`ifdef WB_ARB_BYPASS_EN
    // A fresh result for an empty queue competes immediately; if it wins it
    // skips the queue entirely, otherwise it is stored as usual.
    assign cand[i]   = !q_empty[i] || req[i];
    assign q_push[i] = req[i] && !(grant_any && (grant_idx == IDX_W'(i)) && q_empty[i]);
`else
    assign cand[i]   = !q_empty[i];
    assign q_push[i] = req[i];
`endif

    wb_queue #(.DEPTH(DEPTH)) u_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (q_push[i]),
      .push_data (in_entry[i]),
      .pop       (q_pop[i]),
      .head      (q_head[i]),
      .count     (q_count[i]),
      .full      (q_full[i]),
      .empty     (q_empty[i])
    );

    a_count_range: assert property (@(posedge clk) disable iff (rst) q_count[i] <= CNT_W'(DEPTH));
  end

  assign OUT_full = q_full;

  // Round-robin pick: scan the requesters starting at rr_ptr and wrapping
  // around, taking the first candidate found. A ROB stall suppresses the
  // grant entirely so nothing is popped.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    if (!IN_stall) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!grant_any && cand[idx]) begin
          grant_any = 1'b1;
          grant_idx = IDX_W'(idx);
        end
      end
    end
  end

  // Entry that the winner supplies: normally its queue head, or with bypass
  // the incoming result when its queue is still empty.
  always_comb begin
    grant_entry = q_head[grant_idx];
`ifdef WB_ARB_BYPASS_EN
    if (q_empty[grant_idx]) grant_entry = in_entry[grant_idx];
`endif
  end

  // Output registers and round-robin pointer. OUT_valid is a pulse; the data
  // and grant id stay put until the next grant so the ROB side sees stable
  // values. The pointer moves just past the winner and stays put otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      OUT_valid <= 1'b0;
      out_entry <= '0;
      out_grant <= '0;
    end else begin
      OUT_valid <= grant_any;
      if (grant_any) begin
        out_entry <= grant_entry;
        out_grant <= NUM_REQ'(1) << grant_idx;
        rr_ptr    <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
      end
    end
  end

  assign OUT_result = out_entry.result;
  assign OUT_tag    = out_entry.tag;
  assign OUT_name   = out_entry.name;
  assign OUT_flags  = FLAG_W'(out_entry.flags);
  assign OUT_grant  = out_grant;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter
// Self-checking bench for wb_arbiter with three requesters and two-deep
// queues. Inputs change on the falling clock edge, outputs are sampled 1 time
// unit after the rising edge. A queue-based reference model tracks the
// expected outputs alongside a vector table, directed sequences and a
// randomized phase.
module tb_wb_arbiter;

  localparam int NREQ  = 3;
  localparam int DEPTH = 2;
  localparam int FW    = 2;
`ifdef WB_ARB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NREQ-1:0]          IN_valid;
  logic [NREQ-1:0][31:0]    IN_result;
  logic [NREQ-1:0][5:0]     IN_tag;
  logic [NREQ-1:0][4:0]     IN_name;
  logic [NREQ-1:0][FW-1:0]  IN_flags;
  logic [NREQ-1:0]          OUT_full;
  logic                     IN_stall;
  logic                     OUT_valid;
  logic [31:0]              OUT_result;
  logic [5:0]               OUT_tag;
  logic [4:0]               OUT_name;
  logic [FW-1:0]            OUT_flags;
  logic [NREQ-1:0]          OUT_grant;

  always #5 clk = ~clk;

  wb_arbiter #(.NUM_REQ(NREQ), .DEPTH(DEPTH), .FLAG_W(FW)) dut (
    .clk        (clk),
    .rst        (rst),
    .IN_valid   (IN_valid),
    .IN_result  (IN_result),
    .IN_tag     (IN_tag),
    .IN_name    (IN_name),
    .IN_flags   (IN_flags),
    .OUT_full   (OUT_full),
    .IN_stall   (IN_stall),
    .OUT_valid  (OUT_valid),
    .OUT_result (OUT_result),
    .OUT_tag    (OUT_tag),
    .OUT_name   (OUT_name),
    .OUT_flags  (OUT_flags),
    .OUT_grant  (OUT_grant)
  );

  typedef struct packed {
    logic [31:0] result;
    logic [5:0]  tag;
    logic [4:0]  name;
    logic [1:0]  flags;
  } ent_t;

  typedef struct {
    logic [2:0] v;
    logic [5:0] t0;
    logic [5:0] t1;
    logic [5:0] t2;
    logic       st;
    logic       ev;
    logic [2:0] eg;
    logic [5:0] et;
    logic [2:0] ef;
  } row_t;

  ent_t            d_ent [NREQ];
  logic [NREQ-1:0] d_valid;
  logic            d_stall;

  ent_t mq [NREQ][$];
  int   m_rr;
  logic m_valid;
  ent_t m_out;
  int   m_grant;

  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic setReq(input int i, input logic v, input logic [5:0] tag);
    d_valid[i]      = v;
    d_ent[i].result = 32'h00AB_0000 | (32'(i) << 8) | 32'(tag);
    d_ent[i].tag    = tag;
    d_ent[i].name   = tag[4:0] ^ 5'(i);
    d_ent[i].flags  = tag[1:0];
  endtask

  task automatic clearReqs();
    for (int i = 0; i < NREQ; i++) setReq(i, 1'b0, 6'd0);
    d_stall = 1'b0;
  endtask

  task automatic modelReset();
    for (int i = 0; i < NREQ; i++) mq[i].delete();
    m_rr    = 0;
    m_valid = 1'b0;
    m_out   = '0;
    m_grant = 0;
  endtask

  // One clock of the arbitration rules: first non-empty (or bypassable)
  // requester at or after the pointer wins unless stalled; then new results
  // are appended to their queues.
  task automatic modelStep();
    int g;
    int idx;
    bit byp  [NREQ];
    bit cand [NREQ];
    g = -1;
    for (int i = 0; i < NREQ; i++) begin
      byp[i]  = BYPASS && d_valid[i] && (d_ent[i].tag != 0) && (mq[i].size() == 0);
      cand[i] = (mq[i].size() > 0) || byp[i];
    end
    if (!d_stall) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_rr + k) % NREQ;
        if (g < 0 && cand[idx]) g = idx;
      end
    end
    m_valid = (g >= 0);
    if (g >= 0) begin
      if (mq[g].size() > 0) m_out = mq[g].pop_front();
      else                  m_out = d_ent[g];
      m_grant = g;
      m_rr    = (g + 1) % NREQ;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (d_valid[i] && d_ent[i].tag != 0 && !(g == i && byp[i]) && mq[i].size() < DEPTH)
        mq[i].push_back(d_ent[i]);
    end
  endtask

  function automatic logic [NREQ-1:0] modelFull();
    logic [NREQ-1:0] f;
    f = '0;
    for (int i = 0; i < NREQ; i++) f[i] = (mq[i].size() == DEPTH);
    return f;
  endfunction

  task automatic driveIdle();
    IN_valid  = '0;
    IN_result = '0;
    IN_tag    = '0;
    IN_name   = '0;
    IN_flags  = '0;
    IN_stall  = 1'b0;
    clearReqs();
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      IN_valid[i]  = d_valid[i];
      IN_result[i] = d_ent[i].result;
      IN_tag[i]    = d_ent[i].tag;
      IN_name[i]   = d_ent[i].name;
      IN_flags[i]  = d_ent[i].flags;
    end
    IN_stall = d_stall;
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string ctx);
    logic [NREQ-1:0] eg;
    eg = '0;
    eg[m_grant] = 1'b1;
    checkVal({ctx, " valid"},  64'(OUT_valid),  64'(m_valid));
    checkVal({ctx, " result"}, 64'(OUT_result), 64'(m_out.result));
    checkVal({ctx, " tag"},    64'(OUT_tag),    64'(m_out.tag));
    checkVal({ctx, " name"},   64'(OUT_name),   64'(m_out.name));
    checkVal({ctx, " flags"},  64'(OUT_flags),  64'(m_out.flags));
    checkVal({ctx, " full"},   64'(OUT_full),   64'(modelFull()));
    if (m_valid) checkVal({ctx, " grant"}, 64'(OUT_grant), 64'(eg));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    driveIdle();
    modelReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    row_t tbl [12];
    int   lat;
    int   pulses;
    logic [31:0] cap_result;
    logic [5:0]  cap_tag;
    logic [4:0]  cap_name;
    logic [NREQ-1:0] cap_grant;
    logic [NREQ-1:0] seen [$];
    logic [NREQ-1:0] exp_seq [4];
    logic [NREQ-1:0] act_g;

    rst = 1'b1;
    driveIdle();
    modelReset();
    #7;
    // reset values
    checkVal("reset valid",  64'(OUT_valid),  64'd0);
    checkVal("reset result", 64'(OUT_result), 64'd0);
    checkVal("reset tag",    64'(OUT_tag),    64'd0);
    checkVal("reset name",   64'(OUT_name),   64'd0);
    checkVal("reset flags",  64'(OUT_flags),  64'd0);
    checkVal("reset grant",  64'(OUT_grant),  64'd0);
    checkVal("reset full",   64'(OUT_full),   64'd0);
    @(negedge clk);
    rst = 1'b0;

    // single push from requester 0, latency and contents
    $display("[TB] single push latency");
    clearReqs();
    setReq(0, 1'b1, 6'd5);
    d_ent[0].result = 32'h1234;
    d_ent[0].name   = 5'd3;
    d_ent[0].flags  = 2'd0;
    lat = 0;
    pulses = 0;
    cap_result = '0; cap_tag = '0; cap_name = '0; cap_grant = '0;
    for (int c = 1; c <= 4; c++) begin
      applyStimulus();
      checkOutput("single");
      if (OUT_valid) begin
        pulses++;
        if (lat == 0) begin
          lat = c;
          cap_result = OUT_result;
          cap_tag = OUT_tag;
          cap_name = OUT_name;
          cap_grant = OUT_grant;
        end
      end
      clearReqs();
    end
    checkVal("single latency", 64'(lat), BYPASS ? 64'd1 : 64'd2);
    checkVal("single pulses",  64'(pulses), 64'd1);
    checkVal("single result",  64'(cap_result), 64'h1234);
    checkVal("single tag",     64'(cap_tag), 64'd5);
    checkVal("single name",    64'(cap_name), 64'd3);
    checkVal("single grant",   64'(cap_grant), 64'b001);

`ifndef WB_ARB_BYPASS_EN
    // vector table: {valid mask, tags, stall} -> {valid, grant, tag, full}
    tbl[0]  = '{3'b001, 6'd5,  6'd0,  6'd0,  1'b0, 1'b0, 3'b000, 6'd0,  3'b000};
    tbl[1]  = '{3'b000, 6'd0,  6'd0,  6'd0,  1'b0, 1'b1, 3'b001, 6'd5,  3'b000};
    tbl[2]  = '{3'b000, 6'd0,  6'd0,  6'd0,  1'b0, 1'b0, 3'b000, 6'd5,  3'b000};
    tbl[3]  = '{3'b011, 6'd6,  6'd7,  6'd0,  1'b0, 1'b0, 3'b000, 6'd5,  3'b000};
    tbl[4]  = '{3'b011, 6'd8,  6'd9,  6'd0,  1'b0, 1'b1, 3'b010, 6'd7,  3'b001};
    tbl[5]  = '{3'b010, 6'd0,  6'd10, 6'd0,  1'b0, 1'b1, 3'b001, 6'd6,  3'b010};
    tbl[6]  = '{3'b000, 6'd0,  6'd0,  6'd0,  1'b1, 1'b0, 3'b000, 6'd6,  3'b010};
    tbl[7]  = '{3'b000, 6'd0,  6'd0,  6'd0,  1'b0, 1'b1, 3'b010, 6'd9,  3'b000};
    tbl[8]  = '{3'b100, 6'd0,  6'd0,  6'd11, 1'b0, 1'b1, 3'b001, 6'd8,  3'b000};
    tbl[9]  = '{3'b010, 6'd0,  6'd0,  6'd0,  1'b0, 1'b1, 3'b010, 6'd10, 3'b000};
    tbl[10] = '{3'b000, 6'd0,  6'd0,  6'd0,  1'b0, 1'b1, 3'b100, 6'd11, 3'b000};
    tbl[11] = '{3'b000, 6'd0,  6'd0,  6'd0,  1'b0, 1'b0, 3'b000, 6'd11, 3'b000};
    $display("[TB] vector table");
    doReset();
    for (int r = 0; r < 12; r++) begin
      clearReqs();
      setReq(0, tbl[r].v[0], tbl[r].t0);
      setReq(1, tbl[r].v[1], tbl[r].t1);
      setReq(2, tbl[r].v[2], tbl[r].t2);
      d_stall = tbl[r].st;
      applyStimulus();
      checkOutput($sformatf("tbl%0d model", r));
      checkVal($sformatf("tbl%0d valid", r), 64'(OUT_valid), 64'(tbl[r].ev));
      checkVal($sformatf("tbl%0d tag", r),   64'(OUT_tag),   64'(tbl[r].et));
      checkVal($sformatf("tbl%0d full", r),  64'(OUT_full),  64'(tbl[r].ef));
      if (tbl[r].ev) checkVal($sformatf("tbl%0d grant", r), 64'(OUT_grant), 64'(tbl[r].eg));
    end
`endif

    // tag 0 is dropped
    $display("[TB] tag zero discard");
    doReset();
    for (int c = 0; c < 4; c++) begin
      clearReqs();
      setReq(1, 1'b1, 6'd0);
      applyStimulus();
      checkOutput("tag0");
      checkVal("tag0 valid", 64'(OUT_valid), 64'd0);
      checkVal("tag0 full1", 64'(OUT_full[1]), 64'd0);
    end

    // fill queue 0 under stall, hold, then drain in order
    $display("[TB] stall and drain");
    doReset();
    clearReqs();
    d_stall = 1'b1;
    setReq(0, 1'b1, 6'd20);
    applyStimulus();
    checkOutput("stall fill0");
    setReq(0, 1'b1, 6'd21);
    applyStimulus();
    checkOutput("stall fill1");
    clearReqs();
    d_stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      applyStimulus();
      checkOutput("stall hold");
      checkVal("stall valid", 64'(OUT_valid), 64'd0);
      checkVal("stall full0", 64'(OUT_full[0]), 64'd1);
    end
    d_stall = 1'b0;
    applyStimulus();
    checkOutput("drain0");
    checkVal("drain0 valid", 64'(OUT_valid), 64'd1);
    checkVal("drain0 tag",   64'(OUT_tag),   64'd20);
    applyStimulus();
    checkOutput("drain1");
    checkVal("drain1 valid", 64'(OUT_valid), 64'd1);
    checkVal("drain1 tag",   64'(OUT_tag),   64'd21);
    applyStimulus();
    checkOutput("drain2");
    checkVal("drain2 valid", 64'(OUT_valid), 64'd0);

    // reset while entries are queued and a write strobe is active
    $display("[TB] reset mid-operation");
    doReset();
    clearReqs();
    setReq(0, 1'b1, 6'd30);
    setReq(1, 1'b1, 6'd31);
    applyStimulus();
    checkOutput("midrst a");
    setReq(0, 1'b1, 6'd32);
    setReq(1, 1'b1, 6'd33);
    applyStimulus();
    checkOutput("midrst b");
    checkVal("midrst pre valid", 64'(OUT_valid), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    checkVal("midrst valid",  64'(OUT_valid),  64'd0);
    checkVal("midrst result", 64'(OUT_result), 64'd0);
    checkVal("midrst tag",    64'(OUT_tag),    64'd0);
    checkVal("midrst name",   64'(OUT_name),   64'd0);
    checkVal("midrst flags",  64'(OUT_flags),  64'd0);
    checkVal("midrst grant",  64'(OUT_grant),  64'd0);
    checkVal("midrst full",   64'(OUT_full),   64'd0);
    @(negedge clk);
    driveIdle();
    modelReset();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus();
      checkOutput("postrst");
      checkVal("postrst valid", 64'(OUT_valid), 64'd0);
    end

    // requesters 2 and 0 only: pointer wraps, grants alternate 0,2,0,2
    $display("[TB] round-robin wrap");
    doReset();
    seen.delete();
    for (int c = 0; c < 7; c++) begin
      clearReqs();
      if (c == 0) begin setReq(0, 1'b1, 6'd40); setReq(2, 1'b1, 6'd41); end
      if (c == 1) begin setReq(0, 1'b1, 6'd42); setReq(2, 1'b1, 6'd43); end
      applyStimulus();
      checkOutput("wrap");
      if (OUT_valid) seen.push_back(OUT_grant);
    end
    exp_seq[0] = 3'b001;
    exp_seq[1] = 3'b100;
    exp_seq[2] = 3'b001;
    exp_seq[3] = 3'b100;
    checkVal("wrap grants", 64'(seen.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      act_g = (k < seen.size()) ? seen[k] : '0;
      checkVal($sformatf("wrap grant%0d", k), 64'(act_g), 64'(exp_seq[k]));
    end

    // randomized traffic against the reference model
    $display("[TB] random traffic");
    doReset();
    for (int c = 0; c < 600; c++) begin
      clearReqs();
      for (int i = 0; i < NREQ; i++) begin
        logic [5:0] t;
        t = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        if (mq[i].size() < DEPTH) setReq(i, 1'($urandom_range(0, 1)), t);
        else                      setReq(i, 1'b0, t);
      end
      d_stall = ($urandom_range(0, 3) == 0);
      applyStimulus();
      checkOutput($sformatf("rand%0d", c));
    end

    clearReqs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
